// File: rtl/sdrc_bist_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sdrc_bist_pkg
// Description : Shared types and constants for the SDRAM Wishbone BIST engine
//               (FSM states, pattern modes, cycle-type codes, LFSR taps).
// Revision    : 1.0 - initial release
// ============================================================================
package sdrc_bist_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_INIT = 3'd1,
        S_WR_BURST  = 3'd2,
        S_WR_GAP    = 3'd3,
        S_RD_BURST  = 3'd4,
        S_RD_GAP    = 3'd5,
        S_FINISH    = 3'd6
    } bist_state_t;

    typedef enum logic [1:0] {
        PAT_INC  = 2'd0,
        PAT_LFSR = 2'd1,
        PAT_WALK = 2'd2,
        PAT_ADDR = 2'd3
    } pat_mode_t;

    localparam logic [2:0]  CTI_CLASSIC = 3'b000;
    localparam logic [2:0]  CTI_INCR    = 3'b010;
    localparam logic [2:0]  CTI_EOB     = 3'b111;

    // Galois feedback taps, applied on a right shift when bit 0 falls out
    localparam logic [31:0] LFSR_TAPS   = 32'h8020_0003;

endpackage : sdrc_bist_pkg
`default_nettype wire

// File: rtl/sdrc_bist_patgen.sv
`default_nettype none
// ============================================================================
// Module      : sdrc_bist_patgen
// Description : BIST data-pattern generator. Loaded with seed/mode at the
//               start of each phase, stepped once per accepted beat, so the
//               read phase regenerates exactly the write-phase sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module sdrc_bist_patgen
    import sdrc_bist_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 26
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load,
    input  logic [DW-1:0] i_seed,
    input  logic [1:0]    i_mode,
    input  logic          i_step,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] o_word
);

    localparam logic [DW-1:0] c_TAPS = DW'(LFSR_TAPS);

    pat_mode_t     r_mode;
    logic [DW-1:0] r_acc;
    logic [DW-1:0] w_lfsr_next;
    logic [DW-1:0] w_addr_ext;

    assign w_lfsr_next = {1'b0, r_acc[DW-1:1]} ^ (r_acc[0] ? c_TAPS : '0);

    generate
        if (DW > AW) begin : g_addr_zext
            assign w_addr_ext = {{(DW-AW){1'b0}}, i_addr};
        end else begin : g_addr_trunc
            assign w_addr_ext = i_addr[DW-1:0];
        end
    endgenerate

    // Pattern accumulator: reload from seed, then advance one step per beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode <= PAT_INC;
            r_acc  <= '0;
        end else if (i_load) begin
            r_mode <= pat_mode_t'(i_mode);
            // An all-zero LFSR state would lock up; start from 1 instead
            if ((pat_mode_t'(i_mode) == PAT_LFSR) && (i_seed == '0))
                r_acc <= DW'(1);
            else
                r_acc <= i_seed;
        end else if (i_step) begin
            case (r_mode)
                PAT_INC:  r_acc <= r_acc + DW'(1);
                PAT_LFSR: r_acc <= w_lfsr_next;
                PAT_WALK: r_acc <= {r_acc[DW-2:0], r_acc[DW-1]};
                default:  r_acc <= r_acc;
            endcase
        end
    end

    assign o_word = (r_mode == PAT_ADDR) ? w_addr_ext : r_acc;

endmodule : sdrc_bist_patgen
`default_nettype wire

// File: rtl/sdrc_wb_bist.sv
`default_nettype none
// ============================================================================
// Module      : sdrc_wb_bist
// Description : Wishbone-master memory BIST. Writes a pattern over a window
//               in incrementing bursts, reads it back and compares each beat,
//               reporting pass/fail, error count and first failing beat.
// Revision    : 1.0 - initial release
// ============================================================================
module sdrc_wb_bist
    import sdrc_bist_pkg::*;
#(
    parameter int APP_AW    = 26,
    parameter int DW        = 32,
    parameter int CNT_W     = 16,
    parameter int BURST_MAX = 8,
    parameter int TIMEOUT   = 1023
) (
    input  logic              wb_clk_i,
    input  logic              resetn,
    input  logic              start,
    input  logic              sdr_init_done,
    input  logic [APP_AW-1:0] cfg_base_addr,
    input  logic [CNT_W-1:0]  cfg_num_words,
    input  logic [3:0]        cfg_burst_len,
    input  logic [1:0]        cfg_pattern,
    input  logic [DW-1:0]     cfg_seed,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [APP_AW-1:0] wb_addr_o,
    output logic [DW/8-1:0]   wb_sel_o,
    output logic [DW-1:0]     wb_dat_o,
    output logic [2:0]        wb_cti_o,
    input  logic              wb_ack_i,
    input  logic [DW-1:0]     wb_dat_i,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [CNT_W-1:0]  err_count,
    output logic [APP_AW-1:0] first_err_addr,
    output logic [DW-1:0]     first_err_data
);

    localparam int                c_TMO_W     = $clog2(TIMEOUT + 1);
    localparam logic [APP_AW-1:0] c_ADDR_STEP = APP_AW'(DW / 8);
    localparam logic [3:0]        c_BMAX      = 4'((BURST_MAX > 15) ? 15 : BURST_MAX);

    bist_state_t         r_state, w_state_nxt;
    logic [APP_AW-1:0]   r_base, r_addr, r_ferr_addr;
    logic [CNT_W-1:0]    r_num, r_remain, r_err;
    logic [3:0]          r_blen, r_beat_left;
    logic                r_single, r_timeout, r_pass;
    logic [1:0]          r_mode;
    logic [DW-1:0]       r_seed, r_ferr_data;
    logic [c_TMO_W-1:0]  r_tmo;

    logic                w_in_burst, w_ack, w_last_beat, w_tmo_hit, w_start;
    logic                w_reload, w_enter_burst, w_mismatch;
    logic [CNT_W-1:0]    w_rem_src;
    logic [3:0]          w_beats, w_cfg_blen;
    logic [DW-1:0]       w_pat;

    assign w_in_burst  = (r_state == S_WR_BURST) || (r_state == S_RD_BURST);
    assign w_ack       = w_in_burst && wb_ack_i;
    assign w_last_beat = w_ack && (r_beat_left == 4'd1);
    assign w_tmo_hit   = w_in_burst && !wb_ack_i && (r_tmo == c_TMO_W'(TIMEOUT - 1));
    assign w_start     = (r_state == S_IDLE) && start;
    // Leaving the last write burst: rewind window for the read phase
    assign w_reload    = (r_state == S_WR_GAP) && (r_remain == '0);
    assign w_rem_src   = w_reload ? r_num : r_remain;
    assign w_beats     = (w_rem_src < CNT_W'(r_blen)) ? w_rem_src[3:0] : r_blen;
    assign w_enter_burst = !w_in_burst &&
                           ((w_state_nxt == S_WR_BURST) || (w_state_nxt == S_RD_BURST));
    assign w_mismatch  = (r_state == S_RD_BURST) && wb_ack_i && (wb_dat_i != w_pat);
    assign w_cfg_blen  = (cfg_burst_len == 4'd0)  ? 4'd1 :
                         (cfg_burst_len > c_BMAX) ? c_BMAX : cfg_burst_len;

    sdrc_bist_patgen #(
        .DW (DW),
        .AW (APP_AW)
    ) u_patgen (
        .clk    (wb_clk_i),
        .rst_n  (resetn),
        .i_load (w_start || w_reload),
        .i_seed (w_start ? cfg_seed : r_seed),
        .i_mode (w_start ? cfg_pattern : r_mode),
        .i_step (w_ack),
        .i_addr (r_addr),
        .o_word (w_pat)
    );

    // State register
    always_ff @(posedge wb_clk_i or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:      if (start) w_state_nxt = S_WAIT_INIT;
            S_WAIT_INIT: if (sdr_init_done)
                             w_state_nxt = (r_num == '0) ? S_FINISH : S_WR_BURST;
            S_WR_BURST:  if (w_tmo_hit)        w_state_nxt = S_FINISH;
                         else if (w_last_beat) w_state_nxt = S_WR_GAP;
            S_WR_GAP:    w_state_nxt = (r_remain == '0) ? S_RD_BURST : S_WR_BURST;
            S_RD_BURST:  if (w_tmo_hit)        w_state_nxt = S_FINISH;
                         else if (w_last_beat) w_state_nxt = S_RD_GAP;
            S_RD_GAP:    w_state_nxt = (r_remain == '0) ? S_FINISH : S_RD_BURST;
            S_FINISH:    w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: config capture, address/count tracking, timeout, compare status
    always_ff @(posedge wb_clk_i or negedge resetn) begin
        if (!resetn) begin
            r_base <= '0;  r_addr <= '0;  r_num <= '0;  r_remain <= '0;
            r_blen <= 4'd1;  r_mode <= '0;  r_seed <= '0;
            r_beat_left <= '0;  r_single <= 1'b0;  r_tmo <= '0;
            r_err <= '0;  r_ferr_addr <= '0;  r_ferr_data <= '0;
            r_timeout <= 1'b0;  r_pass <= 1'b0;
        end else begin
            if (w_start) begin
                r_base <= cfg_base_addr;  r_addr <= cfg_base_addr;
                r_num  <= cfg_num_words;  r_remain <= cfg_num_words;
                r_blen <= w_cfg_blen;  r_mode <= cfg_pattern;  r_seed <= cfg_seed;
                r_err <= '0;  r_ferr_addr <= '0;  r_ferr_data <= '0;
                r_timeout <= 1'b0;  r_pass <= 1'b0;
            end
            if (w_reload) begin
                r_remain <= r_num;
                r_addr   <= r_base;
            end
            if (w_enter_burst) begin
                r_beat_left <= w_beats;
                r_single    <= (w_beats == 4'd1);
                r_tmo       <= '0;
            end
            if (w_ack) begin
                r_addr      <= r_addr + c_ADDR_STEP;
                r_remain    <= r_remain - CNT_W'(1);
                r_beat_left <= r_beat_left - 4'd1;
                r_tmo       <= '0;
            end else if (w_in_burst) begin
                r_tmo <= r_tmo + c_TMO_W'(1);
            end
            if (w_tmo_hit) r_timeout <= 1'b1;
            if (w_mismatch) begin
                if (r_err == '0) begin
                    r_ferr_addr <= r_addr;
                    r_ferr_data <= wb_dat_i;
                end
                if (r_err != '1) r_err <= r_err + CNT_W'(1);
            end
            if ((w_state_nxt == S_FINISH) && (r_state != S_FINISH))
                r_pass <= !w_tmo_hit && !r_timeout && (r_err == '0);
        end
    end

    assign wb_cyc_o  = w_in_burst;
    assign wb_stb_o  = w_in_burst;
    assign wb_we_o   = (r_state == S_WR_BURST);
    assign wb_addr_o = r_addr;
    assign wb_sel_o  = w_in_burst ? '1 : '0;
    assign wb_dat_o  = (r_state == S_WR_BURST) ? w_pat : '0;
    assign wb_cti_o  = (!w_in_burst || r_single) ? CTI_CLASSIC :
                       (r_beat_left == 4'd1)     ? CTI_EOB : CTI_INCR;

    assign busy           = (r_state != S_IDLE) && (r_state != S_FINISH);
    assign done           = (r_state == S_FINISH);
    assign pass           = r_pass;
    assign timeout        = r_timeout;
    assign err_count      = r_err;
    assign first_err_addr = r_ferr_addr;
    assign first_err_data = r_ferr_data;

endmodule : sdrc_wb_bist
`default_nettype wire

// File: tb/tb_sdrc_wb_bist.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdrc_wb_bist
// Description : Self-checking bench for sdrc_wb_bist with a Wishbone memory
//               model, bit-flip injection, a beat scoreboard and directed
//               timeout / zero-length / mid-test reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdrc_wb_bist;

    localparam int AW = 26;
    localparam int DW = 32;
    localparam int CW = 16;
    localparam logic [31:0] TAPS = 32'h8020_0003;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    logic          init_done = 1'b1;
    logic [AW-1:0] cfg_base = '0;
    logic [CW-1:0] cfg_num = '0;
    logic [3:0]    cfg_blen = '0;
    logic [1:0]    cfg_pat = '0;
    logic [DW-1:0] cfg_seed = '0;

    logic          wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i;
    logic [AW-1:0] wb_addr_o;
    logic [3:0]    wb_sel_o;
    logic [DW-1:0] wb_dat_o, wb_dat_i;
    logic [2:0]    wb_cti_o;
    logic          busy, done, pass, timeout;
    logic [CW-1:0] err_count;
    logic [AW-1:0] first_err_addr;
    logic [DW-1:0] first_err_data;

    sdrc_wb_bist #(
        .APP_AW(AW), .DW(DW), .CNT_W(CW), .BURST_MAX(8), .TIMEOUT(15)
    ) dut (
        .wb_clk_i(clk), .resetn(resetn), .start(start), .sdr_init_done(init_done),
        .cfg_base_addr(cfg_base), .cfg_num_words(cfg_num), .cfg_burst_len(cfg_blen),
        .cfg_pattern(cfg_pat), .cfg_seed(cfg_seed),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_addr_o(wb_addr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
        .wb_cti_o(wb_cti_o), .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .err_count(err_count), .first_err_addr(first_err_addr),
        .first_err_data(first_err_data)
    );

    always #5 clk = ~clk;

    // ---------------- memory model with ack gating and bit-flip injection
    logic [31:0]   mem [0:63];
    int unsigned   acks_total = 0;
    int unsigned   ack_stop = 32'hFFFF_FFFF;
    logic          inj_en = 1'b0;
    logic [AW-1:0] inj_lo = '0, inj_hi = '0;
    logic [31:0]   inj_mask = '0;

    assign wb_ack_i = wb_cyc_o && wb_stb_o && (acks_total < ack_stop);
    always_comb begin
        wb_dat_i = mem[wb_addr_o[7:2]];
        if (inj_en && !wb_we_o && (wb_addr_o >= inj_lo) && (wb_addr_o <= inj_hi))
            wb_dat_i = wb_dat_i ^ inj_mask;
    end
    always @(posedge clk) begin
        if (wb_ack_i) begin
            acks_total <= acks_total + 1;
            if (wb_we_o) mem[wb_addr_o[7:2]] <= wb_dat_o;
        end
    end

    // ---------------- checking helpers
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pat_word(input int mode, input logic [31:0] seed,
                                             input int idx, input logic [AW-1:0] addr);
        logic [31:0] x;
        int sh;
        case (mode)
            0: pat_word = seed + 32'(idx);
            1: begin
                x = (seed == 0) ? 32'd1 : seed;
                for (int k = 0; k < idx; k++)
                    x = x[0] ? ((x >> 1) ^ TAPS) : (x >> 1);
                pat_word = x;
            end
            2: begin
                sh = idx % 32;
                pat_word = (sh == 0) ? seed : ((seed << sh) | (seed >> (32 - sh)));
            end
            default: pat_word = 32'(addr);
        endcase
    endfunction

    // ---------------- scoreboard
    typedef struct packed {
        logic [3:0]    sel;
        logic          we;
        logic [AW-1:0] addr;
        logic [2:0]    cti;
        logic [31:0]   data;
    } beat_t;

    beat_t q[$];
    logic  gap_pending = 1'b0;

    task automatic push_expected(input int mode, input logic [31:0] seed, input int n,
                                 input int blen, input logic [AW-1:0] base, input int limit);
        int eff, pushed, idx, rem, b;
        beat_t e;
        eff = (blen == 0) ? 1 : ((blen > 8) ? 8 : blen);
        pushed = 0;
        for (int ph = 0; ph < 2; ph++) begin
            idx = 0;
            rem = n;
            while (rem > 0) begin
                b = (rem < eff) ? rem : eff;
                for (int k = 0; k < b; k++) begin
                    e.sel  = 4'hF;
                    e.we   = (ph == 0);
                    e.addr = base + AW'(4 * idx);
                    e.cti  = (b == 1) ? 3'b000 : ((k == b - 1) ? 3'b111 : 3'b010);
                    e.data = (ph == 0) ? pat_word(mode, seed, idx, e.addr) : 32'h0;
                    if (pushed < limit) q.push_back(e);
                    pushed++;
                    idx++;
                end
                rem -= b;
            end
        end
    endtask

    // Pop one expected beat per acknowledged beat; check the idle gap after EOB
    always @(negedge clk) begin
        beat_t e;
        if (!resetn) begin
            gap_pending <= 1'b0;
        end else begin
            if (gap_pending) begin
                chk("gap_idle", 64'(wb_cyc_o | wb_stb_o), 64'd0);
                gap_pending <= 1'b0;
            end
            if (wb_ack_i) begin
                chk("sb_nonempty", 64'(q.size() != 0), 64'd1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("beat_ctl", 64'({wb_sel_o, wb_we_o, wb_addr_o, wb_cti_o}),
                        64'({e.sel, e.we, e.addr, e.cti}));
                    if (e.we) chk("beat_wdata", 64'(wb_dat_o), 64'(e.data));
                end
                if (wb_cti_o != 3'b010) gap_pending <= 1'b1;
            end
        end
    end

    task automatic wait_done(input int budget, output int stalls, output bit seen);
        stalls = 0;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (wb_stb_o && !wb_ack_i) stalls++;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_seen", 64'(seen), 64'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
    endtask

    // ---------------- vector table
    typedef struct {
        int            mode;
        logic [31:0]   seed;
        int            n;
        int            blen;
        logic [AW-1:0] base;
        bit            inj;
        logic [AW-1:0] ilo, ihi;
        logic [31:0]   imask;
        int            exp_err;
        bit            exp_pass;
        logic [AW-1:0] exp_faddr;
        logic [31:0]   exp_fdata;
    } tv_t;

    tv_t tv [5];

    task automatic run_vec(input tv_t v);
        int  stalls;
        bit  seen;
        cfg_pat  = 2'(v.mode);
        cfg_seed = v.seed;
        cfg_num  = CW'(v.n);
        cfg_blen = 4'(v.blen);
        cfg_base = v.base;
        inj_en   = v.inj;
        inj_lo   = v.ilo;
        inj_hi   = v.ihi;
        inj_mask = v.imask;
        push_expected(v.mode, v.seed, v.n, v.blen, v.base, 2 * v.n);
        pulse_start();
        wait_done(1000, stalls, seen);
        chk("pass", 64'(pass), 64'(v.exp_pass));
        chk("err_count", 64'(err_count), 64'(v.exp_err));
        chk("first_err_addr", 64'(first_err_addr), 64'(v.exp_faddr));
        chk("first_err_data", 64'(first_err_data), 64'(v.exp_fdata));
        chk("timeout_flag", 64'(timeout), 64'd0);
        chk("busy_at_done", 64'(busy), 64'd0);
        chk("sb_drained", 64'(q.size()), 64'd0);
        tick();
        chk("done_pulse", 64'(done), 64'd0);
        chk("pass_hold", 64'(pass), 64'(v.exp_pass));
        inj_en = 1'b0;
    endtask

    initial begin
        int  stalls, cyc_seen;
        bit  seen, found;

        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        //          mode seed          n   bl base   inj ilo    ihi    mask          err pass faddr  fdata
        tv[0] = '{0, 32'h0000_0100, 16, 8,  26'h00, 0, 26'h0,  26'h0,  32'h0,         0, 1, 26'h0,  32'h0};
        tv[1] = '{1, 32'h0000_0000, 5,  4,  26'h80, 0, 26'h0,  26'h0,  32'h0,         0, 1, 26'h0,  32'h0};
        tv[2] = '{3, 32'h0000_0000, 8,  4,  26'h40, 1, 26'h4C, 26'h4C, 32'h10,        1, 0, 26'h4C, 32'h5C};
        tv[3] = '{2, 32'h8000_0001, 6,  0,  26'hC0, 0, 26'h0,  26'h0,  32'h0,         0, 1, 26'h0,  32'h0};
        tv[4] = '{0, 32'hFFFF_FFFE, 10, 15, 26'h10, 1, 26'h14, 26'h1C, 32'hFFFF_FFFF, 3, 0, 26'h14, 32'h0};

        // Reset state
        tick();
        tick();
        chk("rst_bus", 64'({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_cti_o}), 64'd0);
        chk("rst_addr_data", 64'({wb_addr_o, wb_dat_o}), 64'd0);
        chk("rst_status", 64'({busy, done, pass, timeout, err_count}), 64'd0);
        chk("rst_first_err", 64'({first_err_addr, first_err_data}), 64'd0);
        resetn = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) run_vec(tv[i]);

        // Memory stops acknowledging after two write beats
        cfg_pat = 2'd0; cfg_seed = 32'h0; cfg_num = 16'd8; cfg_blen = 4'd4; cfg_base = 26'h0;
        push_expected(0, 32'h0, 8, 4, 26'h0, 2);
        ack_stop = acks_total + 2;
        pulse_start();
        wait_done(200, stalls, seen);
        chk("tmo_stall_cycles", 64'(stalls), 64'd15);
        chk("tmo_flag", 64'(timeout), 64'd1);
        chk("tmo_pass", 64'(pass), 64'd0);
        chk("tmo_bus_released", 64'(wb_cyc_o | wb_stb_o), 64'd0);
        chk("tmo_sb_drained", 64'(q.size()), 64'd0);
        tick();
        chk("tmo_done_pulse", 64'(done), 64'd0);
        ack_stop = 32'hFFFF_FFFF;

        // Zero-length test with delayed SDRAM init
        init_done = 1'b0;
        cfg_num = 16'd0;
        pulse_start();
        cyc_seen = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (wb_cyc_o) cyc_seen++;
        end
        chk("n0_no_bus", 64'(cyc_seen), 64'd0);
        chk("n0_no_done_early", 64'(done), 64'd0);
        init_done = 1'b1;
        tick();
        chk("n0_done", 64'(done), 64'd1);
        chk("n0_pass", 64'(pass), 64'd1);
        chk("n0_busy", 64'(busy), 64'd0);
        tick();

        // Reset asserted during a read burst, then a clean rerun
        cfg_pat = 2'd0; cfg_seed = 32'h100; cfg_num = 16'd16; cfg_blen = 4'd8; cfg_base = 26'h0;
        push_expected(0, 32'h100, 16, 8, 26'h0, 32);
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (wb_cyc_o && !wb_we_o) begin
                found = 1'b1;
                break;
            end
        end
        chk("rst_mid_read_reached", 64'(found), 64'd1);
        resetn = 1'b0;
        #1;
        chk("rst_mid_cyc_stb", 64'({wb_cyc_o, wb_stb_o}), 64'd0);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        q.delete();
        tick();
        tick();
        resetn = 1'b1;
        tick();
        run_vec(tv[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_sdrc_wb_bist
`default_nettype wire

// File: doc/sdrc_wb_bist.md
Name: sdrc_wb_bist

Overview:
- Parametrised, synthesizable Wishbone master built-in self-test engine for the SDRAM controller's Wishbone port.
- After sdr_init_done, writes a programmable data pattern over an address window using incrementing bursts, reads the window back and compares beat by beat.
- Reports pass/fail, error count and first failing address/data.
- Sits in place of the bench-side Wishbone driver and can be used for on-chip memory test.

Parameters:
- APP_AW, 26, Wishbone byte-address width.
- DW, 32, Wishbone data width (multiple of 8).
- CNT_W, 16, width of the word-count and error-count registers.
- BURST_MAX, 8, maximum beats per Wishbone burst (power of 2, ≥1).
- TIMEOUT, 1023, cycles without wb_ack_i before a beat aborts.

Ports:
- wb_clk_i  in  1  Wishbone/system clock; all logic on its rising edge.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; begins a test when idle.
- sdr_init_done  in  1  SDRAM initialisation complete.
- cfg_base_addr  in  APP_AW  window start byte address, DW/8-aligned.
- cfg_num_words  in  CNT_W  words to test; 0 is legal.
- cfg_burst_len  in  4  beats per burst, 1..BURST_MAX; 0 is treated as 1; values above BURST_MAX are clipped.
- cfg_pattern  in  2  pattern mode: 0 incrementing, 1 LFSR, 2 walking-one, 3 address-as-data.
- cfg_seed  in  DW  pattern seed.
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone controls.
- wb_addr_o  out  APP_AW  byte address.
- wb_sel_o  out  DW/8  byte enables.
- wb_dat_o  out  DW  write data.
- wb_cti_o  out  3  cycle type.
- wb_ack_i  in  1  Wishbone acknowledge.
- wb_dat_i  in  DW  read data.
- busy, done, pass, timeout  out  1 each  status.
- err_count  out  CNT_W  error count.
- first_err_addr  out  APP_AW  address of the first mismatch.
- first_err_data  out  DW  data read at the first mismatch.

Behaviour:
- Reset: all outputs 0, except wb_sel_o = 0 and wb_cti_o = 3'b000. State IDLE.
- Reset asserted mid-test: bus released immediately (async clear of cyc/stb); status cleared.
- States: IDLE -> WAIT_INIT -> WR_BURST -> WR_GAP -> … -> RD_BURST -> RD_GAP -> … -> FINISH -> IDLE.
- IDLE:
  - start latches all cfg_* inputs, clears the status outputs, sets busy = 1 and moves to WAIT_INIT.
  - start while busy is ignored.
- WAIT_INIT: waits for sdr_init_done = 1.
  - If cfg_num_words = 0, goes straight to FINISH with pass = 1.
- Burst length: beats = min(effective cfg_burst_len, remaining words).
- During a burst:
  - cyc = stb = 1 and sel = all ones.
  - cti = 3'b010 on every beat except the last, which uses 3'b111. A 1-beat burst uses cti = 3'b000.
  - Address and data advance on each cycle where wb_ack_i = 1; the address increments by DW/8.
  - wb_we_o = 1 in write states and 0 in read states.
- GAP states: cyc and stb are 0 for exactly one cycle between bursts.
  - After the last write burst, the engine moves to the read phase and restarts the address at cfg_base_addr.
- Pattern: regenerated from cfg_seed at the start of the read phase, so read expected data matches write data with zero storage.
  - Mode 0: seed + index.
  - Mode 1: Galois LFSR, taps 0x80200003 truncated to DW, stepped once per beat; an all-zero seed is replaced with 1.
  - Mode 2: seed rotated left by (index mod DW).
  - Mode 3: data = address, zero-extended or truncated to DW.
- Compare:
  - On a read ack, wb_dat_i is compared against the expected word in the same cycle.
  - On mismatch, err_count increments and saturates at all ones.
  - The first mismatch latches first_err_addr and first_err_data; later mismatches do not overwrite them.
- Timeout:
  - The counter resets on every ack and on entering a burst.
  - When it reaches TIMEOUT with stb high, the engine drops cyc/stb next cycle, sets timeout = 1 and goes to FINISH with pass = 0.
- FINISH:
  - done is a 1-cycle pulse.
  - pass = (err_count == 0) && !timeout.
  - busy = 0.
  - Status holds until the next start.
- Wrap-around: address arithmetic is modulo 2^APP_AW; no error is raised on wrap.
- An ack while stb = 0 is ignored.

Decomposition:
- Package sdrc_bist_pkg holds:
  - the state enum;
  - the pattern-mode enum;
  - CTI constants (CLASSIC 3'b000, INCR 3'b010, EOB 3'b111);
  - the LFSR tap constant.
- Sub-module sdrc_bist_patgen (parameter DW) takes load/seed/mode/step/addr and outputs the current pattern word. The top instantiates it once, reloaded per phase.

Test Plan:
- Mode 0, seed 0x100, 16 words, burst 8, base 0x0, ideal memory -> 2 write bursts + 2 read bursts.
  - cti sequence 010×7,111 per burst.
  - Data 0x100..0x10F, pass = 1, err_count = 0.
- Mode 1, seed 0, 5 words, burst 4 -> bursts of 4 and 1 (the 1-beat burst uses cti 000); LFSR starts from 1; pass = 1.
- Inject a bit flip on the read of word 3 (addr base+0xC) in mode 3 -> err_count = 1, first_err_addr = base+0xC, pass = 0.
- Memory stops acking mid-write, TIMEOUT = 15 -> cyc drops after 15 cycles, timeout = 1, done pulse, pass = 0.
- cfg_num_words = 0 with sdr_init_done delayed 50 cycles -> no bus activity, done 1 cycle after init, pass = 1.
- Assert resetn low during a read burst -> cyc/stb = 0 immediately, busy = 0; a subsequent start runs a full clean test.
